// File: rtl/convmax_pkg.sv
// convmax_pkg: shared window geometry, sample types and feeder states for the convmax front end.
package convmax_pkg;
  localparam int WIN_LEN = 48;
  localparam int NPOS = 32;
  localparam int STRIDE = 32;
  localparam int KLEN = 8;
  typedef logic [7:0] pixel_t;
  typedef logic [15:0] val_t;
  typedef enum logic [1:0] {FILL, EVAL, EMIT} state_t;
endpackage

// File: rtl/convmax_winbuf.sv
// convmax_winbuf: 48-sample pixel shift register; element 0 is the oldest sample.
module convmax_winbuf
  import convmax_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   shift_i,
  input  pixel_t                 din_i,
  output pixel_t [0:WIN_LEN-1]   win_o
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) win_o <= '0;
    else if (shift_i) win_o <= {win_o[1:WIN_LEN-1], din_i};
endmodule

// File: rtl/convmax_feeder.sv
// convmax_feeder: builds overlapping 48-pixel windows (stride 32) for the conv stage,
// holds its coefficients and reduces per-window maxima to one result per row.
module convmax_feeder
  import convmax_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int POS_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  pixel_t               pix_data,
  input  logic                 pix_valid,
  input  logic                 pix_last,
  output logic                 pix_ready,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  pixel_t               coef_data,
  output pixel_t [0:WIN_LEN-1] win_data,
  output pixel_t [0:KLEN-1]    gauss,
  input  val_t                 cm_maxval,
  input  logic [7:0]           cm_maxpos,
  output logic                 res_valid,
  input  logic                 res_ready,
  output val_t                 res_maxval,
  output logic [POS_W-1:0]     res_pos
);
  localparam int LW = $clog2(LAT + 1);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, need_q, need_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [POS_W-1:0] base_q, base_d, run_pos_q, run_pos_d;
  val_t run_max_q, run_max_d;
  logic last_pend_q, last_pend_d;
  pixel_t [0:KLEN-1] gauss_q;
  logic accept, sample;
  assign pix_ready = state_q == FILL;
  assign accept = pix_valid && pix_ready;
  assign sample = state_q == EVAL && lat_q == '0;
  assign res_valid = state_q == EMIT;
  assign res_maxval = run_max_q;
  assign res_pos = run_pos_q;
  assign gauss = gauss_q;
  convmax_winbuf u_winbuf (
    .clk     (clk),
    .reset_n (reset_n),
    .shift_i (accept),
    .din_i   (pix_data),
    .win_o   (win_data)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    need_d = need_q;
    lat_d = lat_q;
    base_d = base_q;
    run_max_d = run_max_q;
    run_pos_d = run_pos_q;
    last_pend_d = last_pend_q;
    if (accept) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_d == need_q) begin
        state_d = EVAL;
        lat_d = LW'(LAT);
        last_pend_d = pix_last;
      end else if (pix_last) state_d = EMIT;
    end
    if (state_q == EVAL && lat_q != '0) lat_d = lat_q - LW'(1);
    // Ties go to the later window, matching the conv stage's own argmax rule
    if (sample) begin
      if (cm_maxval >= run_max_q) begin
        run_max_d = cm_maxval;
        run_pos_d = base_q + POS_W'(cm_maxpos);
      end
      if (last_pend_q) state_d = EMIT;
      else begin
        state_d = FILL;
        need_d = 6'(STRIDE);
        cnt_d = '0;
        base_d = base_q + POS_W'(STRIDE);
      end
    end
    if (state_q == EMIT && res_ready) begin
      state_d = FILL;
      run_max_d = '0;
      run_pos_d = '0;
      base_d = '0;
      need_d = 6'(WIN_LEN);
      cnt_d = '0;
      last_pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= FILL;
      cnt_q <= '0;
      need_q <= 6'(WIN_LEN);
      lat_q <= '0;
      base_q <= '0;
      run_max_q <= '0;
      run_pos_q <= '0;
      last_pend_q <= 1'b0;
      gauss_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      need_q <= need_d;
      lat_q <= lat_d;
      base_q <= base_d;
      run_max_q <= run_max_d;
      run_pos_q <= run_pos_d;
      last_pend_q <= last_pend_d;
      if (coef_we) gauss_q[coef_addr] <= coef_data;
    end
endmodule

// File: doc/convmax_feeder.md
Name: convmax_feeder

Overview:
- Front end of the laser-line peak detector.
- Accepts a serial 8-bit pixel stream, one camera row at a time, and assembles 48-sample overlapping windows (stride 32) for the parallel convolve-and-max stage.
- Holds the 8 Gaussian coefficients that stage consumes.
- Samples the stage's per-window max, tracks the row-wide peak, and emits one (maxval, absolute position) result per row over a valid/ready handshake.

Parameters:
- LAT, 2: cycles from a new stable window to a valid cm_maxval/cm_maxpos (convolution pipeline depth); must be ≥1.
- POS_W, 16: width of the absolute pixel position in a row.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pix_data  in  8  pixel sample
- pix_valid  in  1  pixel beat valid
- pix_last  in  1  beat is the last pixel of the row
- pix_ready  out  1  feeder accepts a beat
- coef_we  in  1  coefficient write strobe
- coef_addr  in  3  coefficient index 0..7
- coef_data  in  8  coefficient value
- win_data  out  8x[0:47]  window to the conv stage; win_data[0] is the oldest sample
- gauss  out  8x[0:7]  coefficient registers
- cm_maxval  in  16  per-window max from the conv stage
- cm_maxpos  in  8  per-window argmax 0..31
- res_valid  out  1  row result valid
- res_ready  in  1  downstream accepts result
- res_maxval  out  16  row peak value
- res_pos  out  POS_W  row peak absolute position

Behaviour:
- Reset (async, any state): FSM→FILL, need=48, base=0, run_max=0, run_pos=0, last_pend=0; win_data, gauss, res_maxval, res_pos all 0; res_valid=0. Any partial row is discarded.
- Coefficients: when coef_we=1, gauss[coef_addr]<=coef_data on the next edge. Writes are accepted in every state and take effect immediately. The writer must write only between rows.
- Pixel accept: beat accepted when pix_valid && pix_ready. pix_ready=1 only in FILL (combinational from state).
- Shift on accept: win_data[0:46]<=win_data[1:47]; win_data[47]<=pix_data; cnt++.
- FILL → EVAL when the accepted beat makes cnt==need. Load lat_cnt=LAT; set last_pend=pix_last.
- FILL → EMIT when the accepted beat has pix_last=1 and cnt+1<need. No window is evaluated; incomplete-window pixels are dropped.
- EVAL: window is held stable, lat_cnt decrements each cycle. At lat_cnt==0, sample cm_*.
  - Update when cm_maxval ≥ run_max (tie: later position wins, matching the stage's intra-window rule): run_max<=cm_maxval; run_pos<=base+cm_maxpos (zero-extended, POS_W wrap unchecked).
  - If last_pend → EMIT.
  - Else → FILL with need=32, cnt=0, base+=32.
- EMIT: res_valid=1 with res_maxval=run_max and res_pos=run_pos, registered and stable until the handshake.
  - On res_ready: res_valid→0; run_max, run_pos, base=0; need=48; cnt=0; last_pend=0; → FILL.
  - res_ready while res_valid=0 is ignored.
- Backpressure: pix_ready=0 throughout EVAL and EMIT. Per window, EVAL occupies LAT+1 cycles.
- Window k base = 32k. A row of 48+32n pixels yields n+1 windows. Trailing pixels that do not complete a window are ignored; pix_last still ends the row.
- Row shorter than 48 pixels: result maxval=0, pos=0.
- pix_last in FILL while pix_valid=0: ignored.

Decomposition:
- Package convmax_pkg:
  - WIN_LEN=48, NPOS=32, STRIDE=32, KLEN=8
  - pixel_t (8b), val_t (16b)
  - state_t enum {FILL, EVAL, EMIT}
- Sub-module convmax_winbuf: 48x8 shift register with shift-enable and async clear. Drives win_data.
- FSM, counters, running max and coefficient registers live in convmax_feeder.

Test Plan:
- Reset, then write coef 0..7 with values 1..8 → gauss={1..8}. Assert reset_n=0 → gauss and win_data all 0 asynchronously, before any clock edge.
- Row of 48 pixels (value = index) with pix_last on beat 47; stub cm returns (100,5) → win_data[i]=i; pix_ready low LAT+1 cycles; exactly one result (100,5).
- Row of 112 pixels (bases 0,32,64); stub returns (50,3), (90,10), (90,1) → result (90,65) by tie rule. win_data[0]=64 during third EVAL.
- Row of 30 pixels, pix_last on beat 29 → immediate result (0,0), no EVAL entered. Next 48-pixel row starts at base 0.
- Hold res_ready=0 for 10 cycles in EMIT → res_valid, res_maxval and res_pos stable; pix_ready=0. Raise res_ready → one handshake, then pix_ready=1 next cycle.
- Assert reset_n mid-EVAL of window 2 → res_valid=0 and all outputs zero. Following 48-pixel row reports base-0 position correctly.
